// File: rtl/instr_fetch_buffer_if.sv
// Bus bundle for the instruction fetch buffer: memory req/ack side, the
// decode-side valid/ready stream, and the redirect request.
interface instr_fetch_buffer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    // master: the fetch buffer itself
    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready, redirect, redirect_pc
    );

    // slave: memory model plus consumer / redirect source
    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: walks fetch_pc through instruction memory with a
// single outstanding req/ack transaction and queues {pc, word} pairs in a
// small first-word-fall-through FIFO for the decode stage.
//
// state | meaning
// IDLE  | no request outstanding; issue when a FIFO slot is free
// WAIT  | request at mem_addr outstanding, its slot is reserved
// DROP  | request outstanding but flushed by redirect; its data is discarded
module instr_fetch_buffer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_buffer_if.master bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_ack;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic              valid;
    logic              flush;
    logic              pop;
    logic              push;

    assign valid = (count != '0);
    assign flush = bus.redirect;
    // A pop coinciding with a redirect is swallowed by the flush.
    assign pop   = valid && bus.instr_ready && !flush;
    // Occupancy after an accepted word lands; a slot was reserved, so no overflow.
    assign count_ack = count + CNT_W'(1) - CNT_W'(pop);

    // Fetch state, fetch pointer and the held request address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= '0;
            addr_q   <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            addr_q   <= addr_next;
        end
    end

    // Next-state, next fetch address and push decision.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        addr_next     = addr_q;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && (count < FULL)) begin
                    state_next = WAIT;
                    addr_next  = fetch_pc;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_next = bus.mem_ack ? IDLE : DROP;
                end else if (bus.mem_ack) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc + ADDR_W'(1);
                    if (count_ack < FULL) begin
                        addr_next = fetch_pc + ADDR_W'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (bus.mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            fetch_pc_next = bus.redirect_pc;
        end
    end

    // FIFO storage, pointers and occupancy; redirect empties it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= bus.mem_rdata;
                pc_mem[wr_ptr]   <= fetch_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.mem_req     = (state != IDLE);
    assign bus.mem_addr    = addr_q;
    assign bus.instr_valid = valid;
    assign bus.instr       = data_mem[rd_ptr];
    assign bus.instr_pc    = pc_mem[rd_ptr];
endmodule
